// File: rtl/note_sequencer.sv
// Note sequencer: queues {frequency, duration, weights} notes and plays them one at a time
// against the oscillator's sample tick, with an optional silent gap between notes.
module note_sequencer #(
  parameter int CPU_CLOCK_FREQ = 50_000_000,
  parameter int FIFO_DEPTH     = 8,
  parameter int GAP_TICKS      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [14:0]                 cmd_frequency,
  input  logic [15:0]                 cmd_duration,
  input  logic [11:0]                 cmd_weights,
  input  logic                        run,
  input  logic                        stop,
  input  logic                        sample_en,
  output logic [14:0]                 nco_frequency,
  output logic [2:0]                  nco_sine_weight,
  output logic [2:0]                  nco_triangle_weight,
  output logic [2:0]                  nco_sawtooth_weight,
  output logic [2:0]                  nco_square_weight,
  output logic                        busy,
  output logic                        note_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);
  localparam logic [15:0]   GAP_LAST = 16'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_e;

  state_e        state_q;
  logic [42:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [14:0]   freq_q;
  logic [11:0]   wts_q;
  logic [15:0]   tick_q, gap_q;
  logic          busy_q, note_done_q;

  logic          push_s, pop_s, more_s;
  logic [42:0]   head_s;
  logic [15:0]   head_dur_s;

  assign cmd_ready  = (count_q != DEPTH) && !stop;
  assign push_s     = cmd_valid && cmd_ready;
  assign pop_s      = (state_q == LOAD);
  assign more_s     = run && (count_q != {CW{1'b0}});
  assign head_s     = mem_q[rd_ptr_q];
  assign head_dur_s = head_s[27:12];

  // Queue storage: data only, occupancy lives in the pointers and count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {cmd_frequency, cmd_duration, cmd_weights};
    end
  end

  // Sequencer FSM together with queue bookkeeping; stop overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      freq_q      <= 15'd0;
      wts_q       <= 12'd0;
      tick_q      <= 16'd0;
      gap_q       <= 16'd0;
      busy_q      <= 1'b0;
      note_done_q <= 1'b0;
    end else if (stop) begin
      state_q     <= IDLE;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      wts_q       <= 12'd0;
      tick_q      <= 16'd0;
      gap_q       <= 16'd0;
      busy_q      <= 1'b0;
      note_done_q <= 1'b0;
    end else begin
      note_done_q <= 1'b0;
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_s && !pop_s)      count_q <= count_q + CW'(1);
      else if (!push_s && pop_s) count_q <= count_q - CW'(1);
      else                       count_q <= count_q;

      case (state_q)
        IDLE: begin
          if (more_s) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          freq_q  <= head_s[42:28];
          wts_q   <= head_s[11:0];
          tick_q  <= (head_dur_s == 16'd0) ? 16'd0 : head_dur_s - 16'd1;
          state_q <= PLAY;
        end
        PLAY: begin
          if (sample_en) begin
            if (tick_q == 16'd0) begin
              note_done_q <= 1'b1;
              wts_q       <= 12'd0;
              gap_q       <= 16'd0;
              if (GAP_TICKS != 0) begin
                state_q <= GAP;
              end else begin
                state_q <= more_s ? LOAD : IDLE;
                busy_q  <= more_s;
              end
            end else begin
              tick_q <= tick_q - 16'd1;
            end
          end
        end
        GAP: begin
          if (sample_en) begin
            if (gap_q == GAP_LAST) begin
              gap_q   <= 16'd0;
              state_q <= more_s ? LOAD : IDLE;
              busy_q  <= more_s;
            end else begin
              gap_q <= gap_q + 16'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign nco_frequency       = freq_q;
  assign nco_sine_weight     = wts_q[11:9];
  assign nco_triangle_weight = wts_q[8:6];
  assign nco_sawtooth_weight = wts_q[5:3];
  assign nco_square_weight   = wts_q[2:0];
  assign busy                = busy_q;
  assign note_done           = note_done_q;
  assign fifo_count          = count_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: stimulus queues expected notes, a negedge monitor
// checks frequency, weights and played tick count on every note_done pulse.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, cmd_valid, cmd_ready, run, stop, sample_en, busy, note_done;
  logic [14:0] cmd_frequency, nco_frequency;
  logic [15:0] cmd_duration;
  logic [11:0] cmd_weights, wts_o;
  logic [2:0]  w_sin, w_tri, w_saw, w_sq;
  logic [3:0]  fifo_count;

  typedef struct {
    logic [14:0] f;
    logic [11:0] w;
    int          ticks;
  } note_t;

  note_t       sb[$];
  note_t       e_mon;
  int          n_total = 0;
  int          n_pass  = 0;
  int          ticks_seen = 0;
  logic [11:0] wt_seen = 12'd0;

  note_sequencer #(.FIFO_DEPTH(8), .GAP_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_frequency(cmd_frequency), .cmd_duration(cmd_duration), .cmd_weights(cmd_weights),
    .run(run), .stop(stop), .sample_en(sample_en), .nco_frequency(nco_frequency),
    .nco_sine_weight(w_sin), .nco_triangle_weight(w_tri), .nco_sawtooth_weight(w_saw),
    .nco_square_weight(w_sq), .busy(busy), .note_done(note_done), .fifo_count(fifo_count)
  );

  assign wts_o = {w_sin, w_tri, w_saw, w_sq};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_note(input logic [14:0] f, input logic [15:0] d, input logic [11:0] w,
                           input bit expect_play, input int ticks);
    note_t n;
    cmd_valid = 1'b1; cmd_frequency = f; cmd_duration = d; cmd_weights = w;
    if (expect_play) begin
      n.f = f; n.w = w; n.ticks = ticks;
      sb.push_back(n);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_sample();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((busy || fifo_count != 4'd0) && k < 400) begin
      pulse_sample();
      k++;
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    check({name, "_count"}, {28'd0, fifo_count}, 32'd0);
    check({name, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  // Monitor: on note_done compare against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      ticks_seen = 0;
    end else if (note_done) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_note_done: got a pulse, required none (t=%0t)", $time);
      end else begin
        e_mon = sb.pop_front();
        check("note_freq", {17'd0, nco_frequency}, {17'd0, e_mon.f});
        check("note_wts", {20'd0, wt_seen}, {20'd0, e_mon.w});
        check("note_ticks", ticks_seen, e_mon.ticks);
        check("silent_at_done", {20'd0, wts_o}, 32'd0);
      end
      ticks_seen = 0;
    end else if (wts_o == 12'd0) begin
      ticks_seen = 0;
    end else begin
      wt_seen = wts_o;
      if (sample_en) ticks_seen++;
    end
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; run = 1'b0; stop = 1'b0; sample_en = 1'b0;
    cmd_frequency = 15'd0; cmd_duration = 16'd0; cmd_weights = 12'd0;
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {28'd0, fifo_count}, 32'd0);
    check("rst_freq", {17'd0, nco_frequency}, 32'd0);
    check("rst_wts", {20'd0, wts_o}, 32'd0);
    check("rst_done", {31'd0, note_done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // Single note, dur=3, two-tick gap
    run = 1'b1;
    push_note(15'h1000, 16'd3, 12'h800, 1'b1, 3);
    tick();
    check("load_busy", {31'd0, busy}, 32'd1);
    tick();
    check("play_freq", {17'd0, nco_frequency}, 32'h1000);
    check("play_sine", {29'd0, w_sin}, 32'd4);
    check("play_wts", {20'd0, wts_o}, 32'h800);
    repeat (3) pulse_sample();
    check("gap_busy", {31'd0, busy}, 32'd1);
    check("gap_silent", {20'd0, wts_o}, 32'd0);
    check("gap_freq_hold", {17'd0, nco_frequency}, 32'h1000);
    pulse_sample();
    check("gap_busy2", {31'd0, busy}, 32'd1);
    pulse_sample();
    check("idle_after_gap", {31'd0, busy}, 32'd0);
    check("single_sb_empty", sb.size(), 32'd0);
    run = 1'b0;

    // Fill queue past depth with run low
    for (int i = 0; i < 8; i++) push_note(15'(32'h100 + i), 16'd0, 12'(i + 1), 1'b1, 1);
    check("full_count", {28'd0, fifo_count}, 32'd8);
    check("full_ready", {31'd0, cmd_ready}, 32'd0);
    push_note(15'h7FF, 16'd5, 12'hFFF, 1'b0, 0);
    check("full_count_after", {28'd0, fifo_count}, 32'd8);
    run = 1'b1;
    drain("fill");
    run = 1'b0;

    // Zero duration plays one tick, then a two-tick note
    push_note(15'h2222, 16'd0, 12'h049, 1'b1, 1);
    push_note(15'h3333, 16'd2, 12'hFFF, 1'b1, 2);
    run = 1'b1;
    drain("dur");
    run = 1'b0;

    // Push during the LOAD pop keeps the count
    push_note(15'h0555, 16'd1, 12'h111, 1'b1, 1);
    check("pp_before", {28'd0, fifo_count}, 32'd1);
    run = 1'b1;
    tick();
    push_note(15'h0666, 16'd1, 12'h222, 1'b1, 1);
    check("pp_same_cycle", {28'd0, fifo_count}, 32'd1);
    drain("pp");
    run = 1'b0;

    // stop mid-PLAY with three notes queued
    run = 1'b1;
    push_note(15'h1234, 16'd10, 12'h0F0, 1'b0, 0);
    push_note(15'h0AA1, 16'd1, 12'h001, 1'b0, 0);
    push_note(15'h0AA2, 16'd1, 12'h002, 1'b0, 0);
    push_note(15'h0AA3, 16'd1, 12'h003, 1'b0, 0);
    check("stop_pre_count", {28'd0, fifo_count}, 32'd3);
    pulse_sample();
    check("stop_pre_busy", {31'd0, busy}, 32'd1);
    check("stop_pre_wts", {20'd0, wts_o}, 32'h0F0);
    stop = 1'b1; cmd_valid = 1'b1; cmd_frequency = 15'h0BBB; cmd_duration = 16'd1;
    cmd_weights = 12'h00F;
    #1;
    check("stop_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    stop = 1'b0; cmd_valid = 1'b0;
    check("stop_wts", {20'd0, wts_o}, 32'd0);
    check("stop_count", {28'd0, fifo_count}, 32'd0);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_done", {31'd0, note_done}, 32'd0);
    repeat (4) pulse_sample();
    check("stop_stays_idle", {31'd0, busy}, 32'd0);
    check("stop_push_dropped", {28'd0, fifo_count}, 32'd0);
    run = 1'b0;

    // Asynchronous reset in the middle of a gap
    run = 1'b1;
    push_note(15'h0321, 16'd0, 12'h007, 1'b1, 1);
    push_note(15'h0456, 16'd4, 12'h038, 1'b0, 0);
    tick();
    pulse_sample();
    pulse_sample();
    check("gap_pre_busy", {31'd0, busy}, 32'd1);
    check("gap_pre_count", {28'd0, fifo_count}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_freq", {17'd0, nco_frequency}, 32'd0);
    check("arst_wts", {20'd0, wts_o}, 32'd0);
    check("arst_count", {28'd0, fifo_count}, 32'd0);
    check("arst_done", {31'd0, note_done}, 32'd0);
    run = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("arst_ready", {31'd0, cmd_ready}, 32'd1);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
